button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Two-channel push-button front end: synchronises, debounces and edge-detects the raw
//  switch inputs that drive the A/B inputs of the lab FSMs (sequence detector, counter).
//  Each channel outputs a clean level and a one-cycle press pulse.
//  The channels are identical and independent, and the block is purely clocked logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive identical synchronised samples needed to accept a change (>=2)
//  CNT_W            3  debounce counter width; must satisfy DEBOUNCE_CYCLES-1 <= 2^CNT_W-1
// PORTS
//  clk      in   1  single clock, all state updates on posedge
//  reset    in   1  synchronous, active-low; reset==0 at a posedge clears all state
//  a_raw    in   1  raw button A, asynchronous to clk, may bounce
//  b_raw    in   1  raw button B, same as a_raw
//  a_level  out  1  debounced level of A (feeds FSM input A)
//  b_level  out  1  debounced level of B (feeds FSM input B)
//  a_pulse  out  1  one-cycle pulse on each accepted press of A
//  b_pulse  out  1  one-cycle pulse on each accepted press of B
//  a_state  out  2  channel A FSM state, for debug
//  b_state  out  2  channel B FSM state, for debug
// BEHAVIOUR
//  Reset (reset==0 at posedge): sync FFs=0, state=IDLE, cnt=0, every output 0. Reset overrides
//   everything. A reset mid-debounce discards the pending change, and no pulse is emitted.
//  Synchroniser: each channel uses 2 FFs, raw->s1->s2. The FSM uses only s2.
//  State encoding: 00 IDLE (stable 0), 01 PRESS_WAIT, 10 HELD (stable 1), 11 RELEASE_WAIT.
//  Transitions at each posedge when reset==1:
//   IDLE:         s2=1 -> PRESS_WAIT, cnt<=1; otherwise stay, cnt<=0
//   PRESS_WAIT:   s2=0 -> IDLE, cnt<=0 (bounce rejected)
//                 s2=1, cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt<=0, pulse<=1
//                 s2=1, otherwise -> cnt<=cnt+1
//   HELD:         s2=0 -> RELEASE_WAIT, cnt<=1; otherwise stay
//   RELEASE_WAIT: s2=1 -> HELD, cnt<=0 (bounce rejected, no new pulse)
//                 s2=0, cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt<=0
//                 s2=0, otherwise -> cnt<=cnt+1
//  cnt never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
//  level is registered: level=1 exactly while the state is HELD or RELEASE_WAIT.
//  pulse is registered: it is 1 only in the cycle after entering HELD and 0 in all other cycles.
//   Releasing the button produces no pulse. Holding the button produces a single pulse.
//  Latency: let E0 be the first posedge that samples raw=1, with raw then held stable.
//   s2=1 after E1, PRESS_WAIT after E2, HELD, level=1 and pulse=1 after E(DEBOUNCE_CYCLES+1).
//   The release path is symmetric: level=0 after E(DEBOUNCE_CYCLES+1) relative to the first raw=0 sample.
//  Any glitch shorter than DEBOUNCE_CYCLES s2-samples is fully rejected, with level and pulse unchanged.
//  Channels are independent, so a_pulse and b_pulse may assert in the same cycle.
//  If raw is held 1 through reset release, a normal press is detected after the full latency
//   from the first post-reset sample, giving exactly one pulse.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. Hold reset=0 for 3 cycles with raw toggling -> all outputs 0, a_state=b_state=00.
//  2. a_raw 0->1 clean, sampled first at E0 -> a_level=1 and a_pulse=1 after E5, a_pulse=0
//     after E6, a_state=10, and exactly one pulse over 20 cycles of holding.
//  3. a_raw bounce 1,0,1,0 over 4 cycles, then 0 -> a_level stays 0, a_pulse never 1,
//     a_state returns to 00.
//  4. While HELD, drive a 2-cycle 0-glitch -> a_state 10->11->10, a_level stays 1, no pulse.
//     A clean release gives a_level=0 five edges after the first raw=0 sample.
//  5. a_raw and b_raw rise on the same edge -> a_pulse and b_pulse are both 1 in the same cycle.
//  6. Assert reset=0 while a_state=01 (cnt=2) with raw still 1, release after 1 cycle -> no pulse
//     during reset, then a normal pulse 5 edges after the first post-reset sample.

Source files
------------

// File: rtl/button_conditioner.sv
// Two-channel push-button front end: each channel synchronises, debounces and
// edge-detects one raw switch into a clean level plus a one-cycle press pulse.

module ButtonChannel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_raw,
    output logic       o_level,
    output logic       o_pulse,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } stateT;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    stateT            r_state;
    stateT            w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_level;
    logic             r_pulse;
    logic             w_pulseNext;

    // Level and pulse are registered alongside the state so they track its next value.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_level <= (w_stateNext == HELD) || (w_stateNext == RELEASE_WAIT);
            r_pulse <= w_pulseNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_pulseNext = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_stateNext = PRESS_WAIT;
                    w_cntNext   = CNT_W'(1);
                end else begin
                    w_cntNext   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = HELD;
                    w_cntNext   = '0;
                    w_pulseNext = 1'b1;
                end else begin
                    w_cntNext   = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!r_sync2) begin
                    w_stateNext = RELEASE_WAIT;
                    w_cntNext   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to 1 restores HELD silently; only IDLE->HELD pulses.
                if (r_sync2) begin
                    w_stateNext = HELD;
                    w_cntNext   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext   = r_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;
    assign o_state = r_state;

endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_raw,
    input  logic       b_raw,
    output logic       a_level,
    output logic       b_level,
    output logic       a_pulse,
    output logic       b_pulse,
    output logic [1:0] a_state,
    output logic [1:0] b_state
);

    ButtonChannel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) channelA (
        .i_clk   (clk),
        .i_reset (reset),
        .i_raw   (a_raw),
        .o_level (a_level),
        .o_pulse (a_pulse),
        .o_state (a_state)
    );

    ButtonChannel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) channelB (
        .i_clk   (clk),
        .i_reset (reset),
        .i_raw   (b_raw),
        .o_level (b_level),
        .o_pulse (b_pulse),
        .o_state (b_state)
    );

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with literal expectations, then
// randomised bouncing inputs checked every cycle against a sample-window debounce model.

module tb_button_conditioner;

    localparam int DC = 4;

    logic       clk;
    logic       reset;
    logic       a_raw;
    logic       b_raw;
    logic       a_level;
    logic       b_level;
    logic       a_pulse;
    logic       b_pulse;
    logic [1:0] a_state;
    logic [1:0] b_state;

    int testsRun    = 0;
    int testsFailed = 0;

    button_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .a_raw   (a_raw),
        .b_raw   (b_raw),
        .a_level (a_level),
        .b_level (b_level),
        .a_pulse (a_pulse),
        .b_pulse (b_pulse),
        .a_state (a_state),
        .b_state (b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a change is accepted once the last DC synchronised samples all disagree
    // with the current level; the state's low bit marks a pending disagreement.
    logic [1:0]    mS1;
    logic [1:0]    mS2;
    logic [DC-1:0] mHist [2];
    logic [1:0]    mLevel;
    logic [1:0]    mPulse;
    logic [1:0]    mState [2];
    bit            modelValid = 1'b0;

    always @(posedge clk) begin
        logic [1:0] rawNow;
        logic       seen;
        rawNow = {b_raw, a_raw};
        if (!reset) begin
            mS1        = '0;
            mS2        = '0;
            mLevel     = '0;
            mPulse     = '0;
            modelValid = 1'b1;
            for (int ch = 0; ch < 2; ch++) begin
                mHist[ch]  = '0;
                mState[ch] = 2'b00;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                seen       = mS2[ch];
                mS2[ch]    = mS1[ch];
                mS1[ch]    = rawNow[ch];
                mHist[ch]  = {mHist[ch][DC-2:0], seen};
                mPulse[ch] = 1'b0;
                if (mHist[ch] == {DC{~mLevel[ch]}}) begin
                    mLevel[ch] = ~mLevel[ch];
                    mPulse[ch] = mLevel[ch];
                end
                mState[ch] = {mLevel[ch], seen != mLevel[ch]};
            end
        end
    end

    function automatic logic [7:0] dutVec();
        return {a_state, b_state, a_level, b_level, a_pulse, b_pulse};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic aVal, input logic bVal, input logic rstVal);
        a_raw = aVal;
        b_raw = bVal;
        reset = rstVal;
    endtask

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("model_compare", dutVec(),
                        {mState[0], mState[1], mLevel[0], mLevel[1], mPulse[0], mPulse[1]});
        end
    end

    initial begin
        int pulseCount;
        int badCount;
        int holdA;
        int holdB;
        logic aVal;
        logic bVal;

        applyStimulus(1'b0, 1'b0, 1'b0);

        // Reset held with raw inputs toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_hold", dutVec(), 8'h00);
            applyStimulus(i[0] == 1'b0, i[0], 1'b0);
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);

        // Clean press: level and pulse after E5, single pulse while held.
        applyStimulus(1'b1, 1'b0, 1'b1);
        pulseCount = 0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 4) checkOutput("press_e4", {6'b0, a_level, a_pulse}, 8'h00);
            if (k == 5) checkOutput("press_e5", {a_state, 4'b0, a_level, a_pulse}, 8'b10_0000_11);
            if (k == 6) checkOutput("press_e6", {7'b0, a_pulse}, 8'h00);
            pulseCount += int'(a_pulse);
        end
        checkOutput("press_one_pulse", 8'(pulseCount), 8'd1);

        // Clean release from HELD.
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) checkOutput("release_e4", {7'b0, a_level}, 8'd1);
            if (k == 5) checkOutput("release_e5", {a_state, 5'b0, a_level}, 8'h00);
        end
        repeat (3) @(negedge clk);

        // Bounce 1,0,1,0 then 0 is rejected.
        badCount = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus((k < 4) ? ~k[0] : 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            if (a_level || a_pulse) badCount++;
        end
        checkOutput("bounce_rejected", 8'(badCount), 8'd0);
        checkOutput("bounce_idle", {6'b0, a_state}, 8'd0);

        // Two-cycle 0-glitch while HELD.
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checkOutput("glitch_pre_held", {6'b0, a_state}, 8'd2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("glitch_g2", {a_state, 4'b0, a_level, a_pulse}, 8'b11_0000_10);
        @(negedge clk);
        @(negedge clk);
        checkOutput("glitch_g4", {a_state, 4'b0, a_level, a_pulse}, 8'b10_0000_10);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) checkOutput("glitch_release_e4", {7'b0, a_level}, 8'd1);
            if (k == 5) checkOutput("glitch_release_e5", {7'b0, a_level}, 8'd0);
        end
        repeat (4) @(negedge clk);

        // Simultaneous press on both channels.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 4) checkOutput("dual_e4", {6'b0, a_pulse, b_pulse}, 8'b00);
            if (k == 5) checkOutput("dual_e5", {6'b0, a_pulse, b_pulse}, 8'b11);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);

        // Reset in PRESS_WAIT with raw held high.
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("rst_mid_pw", {6'b0, a_state}, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rst_mid_cleared", dutVec(), 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 4) checkOutput("rst_after_f4", {7'b0, a_pulse}, 8'd0);
            if (k == 5) checkOutput("rst_after_f5", {6'b0, a_level, a_pulse}, 8'b11);
            if (k == 6) checkOutput("rst_after_f6", {7'b0, a_pulse}, 8'd0);
        end

        // Randomised bouncing inputs with occasional resets.
        holdA = 0;
        holdB = 0;
        aVal  = 1'b0;
        bVal  = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (holdA == 0) begin
                aVal  = 1'($urandom_range(0, 1));
                holdA = $urandom_range(1, 8);
            end
            if (holdB == 0) begin
                bVal  = 1'($urandom_range(0, 1));
                holdB = $urandom_range(1, 8);
            end
            holdA--;
            holdB--;
            applyStimulus(aVal, bVal, $urandom_range(0, 199) != 0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
